if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a single-outstanding-request instruction-memory handshake with variable latency.
- Holds each fetched instruction in a one-entry output buffer until the IF/ID register takes it.
- Honours downstream stall and branch/jump redirect, discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  downstream hold; IF/ID does not take the output this cycle.
redirect_i  input  1  branch/jump taken, resolved in ID.
redirect_pc_i  input  32  redirect target; bits [1:0] forced to 0 internally.
inst_req_o  output  1  fetch request (combinational).
inst_addr_o  output  32  fetch address; stable while inst_req_o=1 and not acked.
inst_ack_i  input  1  memory accepts the request and returns data this cycle; meaningful only when inst_req_o=1.
inst_rdata_i  input  32  instruction word; valid when inst_ack_i=1.
if_pc  output  32  PC of the buffered instruction (registered).
if_inst  output  32  buffered instruction (registered).
if_valid  output  1  buffer holds a live instruction (registered).

Behaviour:
Interface and reset:
- Single clock domain on clk.
- rst is synchronous and active-high. While rst=1 at a clock edge:
  - pc <= RESET_PC and state <= IDLE.
  - if_pc <= 0, if_inst <= 0, if_valid <= 0.
  - inst_req_o = 0 while in IDLE.
- Reset mid-request abandons the request. An ack arriving in IDLE is ignored.

State machine:
- IDLE: inst_req_o=0. Moves to REQ on the first edge with rst=0.
- REQ:
  - inst_addr_o = pc.
  - inst_req_o = (!if_valid) || (!stall); a request is issued only if the buffer is empty or being consumed this cycle.
- DROP:
  - Entered when a redirect hits an outstanding, unacked request.
  - inst_req_o=1 and inst_addr_o = the old address, held until ack.
  - The acked data is discarded. Next state REQ with pc already equal to the redirect target.

Consume and fill:
- Consume: if_valid && !stall at an edge means IF/ID captured if_pc/if_inst. The buffer clears unless it is refilled that edge.
- Fill: in REQ, inst_req_o && inst_ack_i && !redirect_i causes, at the edge:
  - if_pc <= pc, if_inst <= inst_rdata_i, if_valid <= 1.
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Same-cycle ack is allowed. With ack every cycle and no stall, throughput is one instruction per cycle.
- Latency: ack at edge N gives if_valid=1 from N+1. The next request is issued in cycle N+1 with pc+4.
- Simultaneous consume and fill: the buffer takes the new entry and if_valid stays 1.
- Stall with a full buffer: inst_req_o drops and if_pc/if_inst/if_valid hold unchanged.

Redirect:
- Redirect has priority over stall and over fill.
- At an edge with redirect_i=1:
  - pc <= {redirect_pc_i[31:2], 2'b00}.
  - if_valid <= 0, squashing the buffered delay-slot-following instruction.
  - Any same-cycle ack is discarded.
  - If a request was outstanding and not acked, next state is DROP; otherwise REQ.
- Redirect while in DROP: update pc to the newest target and stay in DROP.
- Redirect in IDLE: ignored.

Other rules:
- pc never changes except by fill, redirect or reset.
- inst_addr_o never changes while a request is outstanding and unacked.

Test Plan:
1. Reset then ack every cycle, stall=0, RESET_PC=0 → if_valid first high at cycle 2 after reset release; if_pc sequence 0,4,8,C on consecutive cycles with matching if_inst.
2. Ack latency 3 cycles → inst_addr_o=0x0 held stable 3 cycles; if_valid pulses 1 cycle per fetch; if_pc 0 then 4 with no duplication or skip.
3. stall=1 for 4 cycles with a full buffer (if_pc=0x8) → inst_req_o=0; if_pc=0x8 and if_inst held; after release, next fetch is 0xC.
4. redirect_i=1, redirect_pc_i=0x0000_0103, outstanding unacked request to 0x10 → state DROP; ack for 0x10 discarded; next inst_addr_o=0x100; if_valid=0 until the 0x100 data arrives.
5. redirect_i together with ack and stall=1 → ack data dropped; if_valid=0 next cycle; next fetch address = target.
6. RESET_PC=32'hFFFF_FFFC, two acks → if_pc 0xFFFF_FFFC then 0x0; rst asserted mid-request → inst_req_o=0 and if_valid=0 next cycle; stray ack ignored.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time and parks each fetched word in a one-entry buffer for IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] target;
  logic        fill;
  logic        consume;
  logic        unused_bits;

  assign target      = {redirect_pc_i[31:2], 2'b00};
  assign unused_bits = ^redirect_pc_i[1:0];

  always_comb begin
    inst_req_o  = 1'b0;
    inst_addr_o = pc;
    unique case (state)
      IDLE: inst_req_o = 1'b0;
      REQ:  inst_req_o = !if_valid || !stall;
      DROP: begin
        inst_req_o  = 1'b1;
        inst_addr_o = drop_addr;
      end
      default: inst_req_o = 1'b0;
    endcase
  end

  assign fill    = (state == REQ) && inst_req_o
                && inst_ack_i && !redirect_i;
  assign consume = if_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
      if_pc     <= 32'h0;
      if_inst   <= 32'h0;
      if_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redirect_i) begin
            pc       <= target;
            if_valid <= 1'b0;
            // an unacked request still owes us a response: swallow it
            if (inst_req_o && !inst_ack_i) begin
              state     <= DROP;
              drop_addr <= pc;
            end
          end else if (fill) begin
            pc       <= pc + 32'd4;
            if_pc    <= pc;
            if_inst  <= inst_rdata_i;
            if_valid <= 1'b1;
          end else if (consume) begin
            if_valid <= 1'b0;
          end
        end
        DROP: begin
          if_valid <= 1'b0;
          if (redirect_i) pc <= target;
          if (inst_ack_i) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, wrap/reset sequence on a
// second instance, then random traffic against a fetch-stream model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_i, inst_ack_i;
  logic [31:0] redirect_pc_i, inst_rdata_i;
  logic        inst_req_o, if_valid;
  logic [31:0] inst_addr_o, if_pc, if_inst;

  logic        rst_w, ack_w, req_w, vld_w;
  logic [31:0] rdata_w, addr_w, pc_w, inst_w;
  logic        stall_w = 1'b0;
  logic        red_w = 1'b0;
  logic [31:0] rpc_w = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_ack_i(inst_ack_i), .inst_rdata_i(inst_rdata_i),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall_w),
    .redirect_i(red_w), .redirect_pc_i(rpc_w),
    .inst_req_o(req_w), .inst_addr_o(addr_w),
    .inst_ack_i(ack_w), .inst_rdata_i(rdata_w),
    .if_pc(pc_w), .if_inst(inst_w), .if_valid(vld_w)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic st, rd,
                              input logic [31:0] rpc,
                              input logic ack, req,
                              input logic [31:0] addr,
                              input logic vld,
                              input logic [31:0] pc);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.ack = ack;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  // fetch-stream model: what the stage owes and what it has delivered
  logic        m_started, m_junk, m_bv;
  logic [31:0] m_pc, m_junk_addr, m_bpc, m_binst, exp_next;

  task automatic model_reset();
    m_started = 1'b0; m_junk = 1'b0; m_bv = 1'b0;
    m_pc = 32'h0; m_junk_addr = 32'h0;
    m_bpc = 32'h0; m_binst = 32'h0; exp_next = 32'h0;
  endtask

  function automatic logic model_req(input logic st);
    return m_started && (m_junk || !m_bv || !st);
  endfunction

  task automatic model_step(input logic r, st, rd,
                            input logic [31:0] rpc,
                            input logic ack);
    logic        req;
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    req = model_req(st);
    if (r) begin
      model_reset();
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      if (!m_junk && !rd && m_bv && !st) begin
        chk("stream_pc", if_pc, exp_next);
        chk("stream_inst", if_inst, mem(exp_next));
        exp_next = exp_next + 32'd4;
      end
      if (rd) begin
        if (req && !ack) begin
          if (!m_junk) m_junk_addr = m_pc;
          m_junk = 1'b1;
        end else begin
          m_junk = 1'b0;
        end
        m_pc = tgt; m_bv = 1'b0; exp_next = tgt;
      end else if (m_junk) begin
        if (ack) m_junk = 1'b0;
      end else if (req && ack) begin
        m_bv = 1'b1; m_bpc = m_pc; m_binst = mem(m_pc);
        m_pc = m_pc + 32'd4;
      end else if (m_bv && !st) begin
        m_bv = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; inst_ack_i = 1'b0; inst_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  vec_t tv[22];

  initial begin
    rst_w = 1'b1; ack_w = 1'b0; rdata_w = 32'h0;
    tv[0]  = mk(0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0);
    tv[1]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
    tv[2]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0);
    tv[3]  = mk(0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4);
    tv[4]  = mk(1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h8);
    tv[5]  = mk(1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h8);
    tv[6]  = mk(1, 0, 32'h0,   1, 0, 32'hC,   1, 32'h8);
    tv[7]  = mk(1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h8);
    tv[8]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h8);
    tv[9]  = mk(0, 0, 32'h0,   0, 1, 32'hC,   0, 32'h8);
    tv[10] = mk(0, 0, 32'h0,   1, 1, 32'hC,   0, 32'h8);
    tv[11] = mk(0, 0, 32'h0,   0, 1, 32'h10,  1, 32'hC);
    tv[12] = mk(0, 1, 32'h103, 0, 1, 32'h10,  0, 32'hC);
    tv[13] = mk(0, 0, 32'h0,   0, 1, 32'h10,  0, 32'hC);
    tv[14] = mk(0, 0, 32'h0,   1, 1, 32'h10,  0, 32'hC);
    tv[15] = mk(0, 0, 32'h0,   0, 1, 32'h100, 0, 32'hC);
    tv[16] = mk(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'hC);
    tv[17] = mk(0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h100);
    tv[18] = mk(1, 1, 32'h200, 1, 1, 32'h104, 0, 32'h100);
    tv[19] = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h100);
    tv[20] = mk(0, 1, 32'h301, 1, 1, 32'h204, 1, 32'h200);
    tv[21] = mk(0, 0, 32'h0,   0, 1, 32'h300, 0, 32'h200);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = 1'b0;
      stall = tv[i].st; redirect_i = tv[i].rd;
      redirect_pc_i = tv[i].rpc; inst_ack_i = tv[i].ack;
      inst_rdata_i = mem(inst_addr_o);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, inst_req_o}, {31'h0, tv[i].req});
      if (tv[i].req)
        chk($sformatf("v%0d_addr", i), inst_addr_o, tv[i].addr);
      chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, tv[i].vld});
      chk($sformatf("v%0d_pc", i), if_pc, tv[i].pc);
      if (tv[i].vld)
        chk($sformatf("v%0d_inst", i), if_inst, mem(tv[i].pc));
      if (i == 0) chk("reset_inst", if_inst, 32'h0);
    end

    // wrap-around and mid-request reset on the high RESET_PC instance
    @(negedge clk); rst_w = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_w = 1'b0; ack_w = 1'b1; rdata_w = mem(addr_w); #1;
    chk("w0_req", {31'h0, req_w}, 32'h0);
    chk("w0_valid", {31'h0, vld_w}, 32'h0);
    @(negedge clk); ack_w = 1'b1; rdata_w = mem(addr_w); #1;
    chk("w1_req", {31'h0, req_w}, 32'h1);
    chk("w1_addr", addr_w, 32'hFFFF_FFFC);
    @(negedge clk); ack_w = 1'b1; rdata_w = mem(addr_w); #1;
    chk("w2_addr", addr_w, 32'h0);
    chk("w2_valid", {31'h0, vld_w}, 32'h1);
    chk("w2_pc", pc_w, 32'hFFFF_FFFC);
    chk("w2_inst", inst_w, mem(32'hFFFF_FFFC));
    @(negedge clk); ack_w = 1'b0; rdata_w = mem(addr_w); #1;
    chk("w3_addr", addr_w, 32'h4);
    chk("w3_pc", pc_w, 32'h0);
    chk("w3_inst", inst_w, mem(32'h0));
    rst_w = 1'b1;
    @(negedge clk); rst_w = 1'b0; ack_w = 1'b1; rdata_w = 32'h1234_5678; #1;
    chk("w4_req", {31'h0, req_w}, 32'h0);
    chk("w4_valid", {31'h0, vld_w}, 32'h0);
    chk("w4_pc", pc_w, 32'h0);
    @(negedge clk); ack_w = 1'b0; rdata_w = mem(addr_w); #1;
    chk("w5_req", {31'h0, req_w}, 32'h1);
    chk("w5_addr", addr_w, 32'hFFFF_FFFC);
    chk("w5_valid", {31'h0, vld_w}, 32'h0);

    // random traffic against the stream model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r, st, rd, ack, er;
      logic [31:0] rpc, ea;
      r   = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      ack = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                        : $urandom;
      @(negedge clk);
      rst = r; stall = st; redirect_i = rd;
      redirect_pc_i = rpc; inst_ack_i = ack;
      inst_rdata_i = mem(inst_addr_o);
      #1;
      er = model_req(st);
      ea = m_junk ? m_junk_addr : m_pc;
      chk("rnd_req", {31'h0, inst_req_o}, {31'h0, er});
      if (er) chk("rnd_addr", inst_addr_o, ea);
      chk("rnd_valid", {31'h0, if_valid}, {31'h0, m_bv});
      if (m_bv) begin
        chk("rnd_pc", if_pc, m_bpc);
        chk("rnd_inst", if_inst, m_binst);
      end
      model_step(r, st, rd, rpc, ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
